// File: rtl/i2s_audio_out_pkg.sv
// Shared types and constants for the I2S audio output path.
package i2s_audio_out_pkg;

   localparam int unsigned I2S_SLOTS_PER_FRAME = 32;
   localparam int unsigned I2S_WORD_BITS       = 16;
   localparam int unsigned SLOT_W              = $clog2(I2S_SLOTS_PER_FRAME);

   typedef struct packed {
      logic [I2S_WORD_BITS-1:0] left;
      logic [I2S_WORD_BITS-1:0] right;
   } stereo_pair_t;

   localparam int unsigned PAIR_W = $bits(stereo_pair_t);

   // Bit of {left,right} driven at the start of a slot (one-slot I2S delay).
   function automatic logic [SLOT_W-1:0] slot_bit_idx(input logic [SLOT_W-1:0] slot);
      return SLOT_W'(0) - slot;
   endfunction

endpackage

// File: rtl/i2s_audio_out_if.sv
// Sample strobe and stereo payload from the DSP into the I2S transmitter.
interface i2s_audio_out_if;
   import i2s_audio_out_pkg::*;

   logic                     audio_valid;
   logic [I2S_WORD_BITS-1:0] dac_in_l;
   logic [I2S_WORD_BITS-1:0] dac_in_r;

   modport master (output audio_valid, output dac_in_l, output dac_in_r);
   modport slave  (input  audio_valid, input  dac_in_l, input  dac_in_r);

endinterface

// File: rtl/i2s_audio_out_sample_fifo.sv
// Synchronous FIFO; a pop and a push in the same cycle pop first, so a full FIFO accepts the push.
module i2s_audio_out_sample_fifo #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [LVL_W-1:0] count_q, count_d;
   logic             full_q, empty_q;
   logic             push_ok, pop_ok;

   assign pop_ok  = pop_i && !empty_q;
   assign push_ok = push_i && (!full_q || pop_ok);

   always_comb begin
      count_d = count_q;
      if (push_ok && !pop_ok) begin
         count_d = count_q + LVL_W'(1);
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - LVL_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (push_ok) wr_q <= wr_q + PTR_W'(1);
         if (pop_ok)  rd_q <= rd_q + PTR_W'(1);
         count_q <= count_d;
         full_q  <= (count_d == LVL_W'(DEPTH));
         empty_q <= (count_d == '0);
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
   end

   assign head_o  = mem_q[rd_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = count_q;

endmodule

// File: rtl/i2s_audio_out.sv
// Buffers DSP stereo samples and serialises them as a 32-slot I2S stream with sticky
// overflow/underflow status.
module i2s_audio_out
   import i2s_audio_out_pkg::*;
#(
   parameter  int unsigned FIFO_DEPTH       = 4,
   parameter  int unsigned BCLK_DIV         = 2,
   parameter  int unsigned UNDERFLOW_REPEAT = 0,
   localparam int unsigned LVL_W            = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   i2s_audio_out_if.slave    audio,
   input  logic              clear_flags,
   output logic              i2s_bclk,
   output logic              i2s_lrclk,
   output logic              i2s_sdata,
   output logic              frame_start,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              overflow,
   output logic              underflow
);
   localparam int unsigned CNT_W = $clog2(BCLK_DIV);
   localparam int unsigned HALF  = BCLK_DIV / 2;

   logic              run_q, run_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   stereo_pair_t      shift_q, shift_d;
   stereo_pair_t      last_q, last_d;
   logic              bclk_q, bclk_d;
   logic              lrclk_q, lrclk_d;
   logic              sdata_q, sdata_d;
   logic              fs_q, fs_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   stereo_pair_t      in_pair_c, head_c;
   logic [PAIR_W-1:0] head_raw;
   logic [PAIR_W-1:0] shift_bits_c;
   logic              fifo_full, fifo_empty;
   logic [LVL_W-1:0]  fifo_lvl;
   logic              push_req_c, pop_evt_c, fifo_pop_c, slot_start_c;

   assign in_pair_c    = '{left: audio.dac_in_l, right: audio.dac_in_r};
   assign head_c       = stereo_pair_t'(head_raw);
   assign shift_bits_c = shift_q;

   // The pair for a frame is taken at the end of the first cycle of slot 0.
   assign push_req_c = enable && audio.audio_valid;
   assign pop_evt_c  = enable && fs_q;
   assign fifo_pop_c = pop_evt_c && !fifo_empty;

   i2s_audio_out_sample_fifo #(
      .WIDTH (PAIR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .flush_i (!enable),
      .push_i  (push_req_c),
      .pop_i   (fifo_pop_c),
      .wdata_i (in_pair_c),
      .head_o  (head_raw),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_lvl)
   );

   always_comb begin
      run_d   = enable;
      cnt_d   = '0;
      slot_d  = '0;
      shift_d = shift_q;
      last_d  = last_q;
      sdata_d = sdata_q;

      // A first enabled cycle after idle is the start of slot 0, not an advance.
      if (enable && run_q) begin
         if (cnt_q == CNT_W'(BCLK_DIV - 1)) begin
            slot_d = slot_q + SLOT_W'(1);
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            slot_d = slot_q;
         end
      end

      slot_start_c = (cnt_d == '0);
      bclk_d       = enable && (cnt_d >= CNT_W'(HALF));
      lrclk_d      = enable && (slot_d >= SLOT_W'(I2S_WORD_BITS));
      fs_d         = enable && slot_start_c && (slot_d == '0);

      if (!enable) begin
         sdata_d = 1'b0;
      end else if (slot_start_c) begin
         sdata_d = shift_bits_c[slot_bit_idx(slot_d)];
      end

      if (!enable) begin
         shift_d = '0;
      end else if (pop_evt_c) begin
         if (fifo_pop_c) begin
            shift_d = head_c;
            last_d  = head_c;
         end else if (UNDERFLOW_REPEAT != 0) begin
            shift_d = last_q;
         end else begin
            shift_d = '0;
         end
      end

      ovf_d = (push_req_c && fifo_full && !fifo_pop_c) || (ovf_q && !clear_flags);
      unf_d = (pop_evt_c && fifo_empty) || (unf_q && !clear_flags);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         run_q   <= 1'b0;
         cnt_q   <= '0;
         slot_q  <= '0;
         shift_q <= '0;
         last_q  <= '0;
         bclk_q  <= 1'b0;
         lrclk_q <= 1'b0;
         sdata_q <= 1'b0;
         fs_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         run_q   <= run_d;
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         bclk_q  <= bclk_d;
         lrclk_q <= lrclk_d;
         sdata_q <= sdata_d;
         fs_q    <= fs_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign i2s_bclk    = bclk_q;
   assign i2s_lrclk   = lrclk_q;
   assign i2s_sdata   = sdata_q;
   assign frame_start = fs_q;
   assign fifo_level  = fifo_lvl;
   assign overflow    = ovf_q;
   assign underflow   = unf_q;

endmodule

// File: tb/tb_i2s_audio_out.sv
// Directed bench for i2s_audio_out: two instances (zero-fill and repeat on underflow),
// BCLK_DIV=2, FIFO_DEPTH=4.
module tb_i2s_audio_out;

   localparam int unsigned DIV = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, en0, en1, clr, sel;
   logic bclk0, lr0, sd0, fs0, ovf0, unf0;
   logic bclk1, lr1, sd1, fs1, ovf1, unf1;
   logic [2:0] lvl0, lvl1;
   logic bclk_m, lr_m, sd_m, fs_m;

   int total = 0;
   int bad   = 0;

   i2s_audio_out_if a0();
   i2s_audio_out_if a1();

   i2s_audio_out #(.FIFO_DEPTH(4), .BCLK_DIV(DIV), .UNDERFLOW_REPEAT(0)) dut0 (
      .clock(clk), .reset(reset), .enable(en0), .audio(a0.slave), .clear_flags(clr),
      .i2s_bclk(bclk0), .i2s_lrclk(lr0), .i2s_sdata(sd0), .frame_start(fs0),
      .fifo_level(lvl0), .overflow(ovf0), .underflow(unf0));

   i2s_audio_out #(.FIFO_DEPTH(4), .BCLK_DIV(DIV), .UNDERFLOW_REPEAT(1)) dut1 (
      .clock(clk), .reset(reset), .enable(en1), .audio(a1.slave), .clear_flags(clr),
      .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1), .frame_start(fs1),
      .fifo_level(lvl1), .overflow(ovf1), .underflow(unf1));

   assign bclk_m = sel ? bclk1 : bclk0;
   assign lr_m   = sel ? lr1   : lr0;
   assign sd_m   = sel ? sd1   : sd0;
   assign fs_m   = sel ? fs1   : fs0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      if (sel) begin
         a1.audio_valid = 1'b1; a1.dac_in_l = l; a1.dac_in_r = r;
      end else begin
         a0.audio_valid = 1'b1; a0.dac_in_l = l; a0.dac_in_r = r;
      end
      tick(1);
      a0.audio_valid = 1'b0;
      a1.audio_valid = 1'b0;
   endtask

   task automatic wait_fs();
      int n = 0;
      while (fs_m !== 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
      check("wait_frame_start", 32'(fs_m), 32'd1);
   endtask

   // Records sdata per slot, counting bclk/lrclk/frame_start/stability deviations.
   task automatic grab(output logic [31:0] word, output int errs);
      errs = 0;
      word = '0;
      for (int s = 0; s < 32; s++) begin
         for (int c = 0; c < int'(DIV); c++) begin
            if (c == 0) word[31-s] = sd_m;
            else if (sd_m !== word[31-s]) errs++;
            if (bclk_m !== 1'(c >= int'(DIV / 2))) errs++;
            if (lr_m !== 1'(s >= 16)) errs++;
            if (fs_m !== 1'(s == 0 && c == 0)) errs++;
            tick(1);
         end
      end
   endtask

   function automatic logic [31:0] fexp(input logic r0, input logic [15:0] l, input logic [15:0] r);
      return {r0, l, r[15:1]};
   endfunction

   task automatic frame_chk(input string tag, input logic [31:0] exp);
      logic [31:0] w;
      int e;
      wait_fs();
      grab(w, e);
      check({tag, "_data"}, w, exp);
      check({tag, "_timing"}, 32'(e), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; en0 = 1'b1; en1 = 1'b0; clr = 1'b0; sel = 1'b0;
      a0.audio_valid = 1'b1; a0.dac_in_l = 16'hFFFF; a0.dac_in_r = 16'hFFFF;
      a1.audio_valid = 1'b0; a1.dac_in_l = 16'h0;    a1.dac_in_r = 16'h0;

      // Reset with enable and audio_valid held high
      tick(3);
      check("rst_outs0", 32'({bclk0, lr0, sd0, fs0, lvl0, ovf0, unf0}), 32'd0);
      check("rst_outs1", 32'({bclk1, lr1, sd1, fs1, lvl1, ovf1, unf1}), 32'd0);
      a0.audio_valid = 1'b0;
      reset = 1'b1;
      tick(1);
      check("unf_before_first", 32'(unf0), 32'd0);
      frame_chk("idle", 32'd0);
      check("unf_idle", 32'(unf0), 32'd1);

      // Single frame A5F0/0F5A
      push(16'hA5F0, 16'h0F5A);
      clr = 1'b1; tick(1); clr = 1'b0;
      check("lvl_one", 32'(lvl0), 32'd1);
      check("flags_cleared", 32'({ovf0, unf0}), 32'd0);
      frame_chk("single", fexp(1'b0, 16'hA5F0, 16'h0F5A));
      check("flags_single", 32'({ovf0, unf0}), 32'd0);
      check("lvl_single", 32'(lvl0), 32'd0);
      check("single_r0", 32'(sd0), 32'd0);

      // Overflow: five pushes into a depth-4 FIFO within one frame
      tick(1);
      for (int k = 1; k <= 4; k++) push(16'h1000 + 16'(k), 16'h2000 + 16'(k));
      check("lvl_full", 32'(lvl0), 32'd4);
      check("ovf_pre", 32'(ovf0), 32'd0);
      push(16'h1005, 16'h2005);
      check("ovf_set", 32'(ovf0), 32'd1);
      check("lvl_hold", 32'(lvl0), 32'd4);
      clr = 1'b1; tick(1); clr = 1'b0;
      check("ovf_clr", 32'(ovf0), 32'd0);
      for (int k = 1; k <= 4; k++)
         frame_chk($sformatf("ovf_p%0d", k),
                   fexp(1'((k - 1) & 1), 16'h1000 + 16'(k), 16'h2000 + 16'(k)));
      frame_chk("ovf_p5_absent", fexp(1'b0, 16'h0, 16'h0));

      // Push into a full FIFO coincident with the frame pop
      tick(1);
      for (int k = 1; k <= 4; k++) push(16'h4000 + 16'(k), 16'hC000 + 16'(k));
      check("lvl_full2", 32'(lvl0), 32'd4);
      wait_fs();
      push(16'h4005, 16'hC005);
      check("lvl_coinc", 32'(lvl0), 32'd4);
      check("ovf_coinc", 32'(ovf0), 32'd0);
      for (int k = 2; k <= 5; k++)
         frame_chk($sformatf("coinc_q%0d", k),
                   fexp(1'((k - 1) & 1), 16'h4000 + 16'(k), 16'hC000 + 16'(k)));
      check("r0_q5", 32'(sd0), 32'd1);
      check("ovf_after_coinc", 32'(ovf0), 32'd0);

      // Drop enable in slot 10
      tick(1);
      push(16'h7777, 16'h3333);
      check("lvl_pre_dis", 32'(lvl0), 32'd1);
      tick(19);
      check("mid_bclk", 32'(bclk0), 32'd1);
      en0 = 1'b0;
      tick(1);
      check("dis_outs", 32'({bclk0, lr0, sd0, fs0, lvl0}), 32'd0);
      check("dis_flags", 32'({ovf0, unf0}), 32'd1);
      push(16'h9999, 16'h9999);
      tick(2);
      check("dis_hold_outs", 32'({bclk0, lr0, sd0, fs0, lvl0}), 32'd0);
      check("dis_hold_flags", 32'({ovf0, unf0}), 32'd1);
      en0 = 1'b1;
      tick(1);
      check("reen_fs", 32'({fs0, bclk0, lr0}), 32'd4);

      // Reset asserted in slot 20
      push(16'h5555, 16'h6666);
      tick(39);
      check("mid_lr", 32'(lr0), 32'd1);
      check("lvl_pre_rst", 32'(lvl0), 32'd1);
      reset = 1'b0;
      tick(1);
      check("rst_mid", 32'({bclk0, lr0, sd0, fs0, lvl0, ovf0, unf0}), 32'd0);
      reset = 1'b1;

      // Underflow repeat on the second instance
      sel = 1'b1;
      en1 = 1'b1;
      push(16'h1234, 16'h8001);
      check("rep_lvl", 32'(lvl1), 32'd1);
      frame_chk("rep_f1", fexp(1'b0, 16'h1234, 16'h8001));
      check("rep_unf0", 32'(unf1), 32'd0);
      frame_chk("rep_f2", fexp(1'b1, 16'h1234, 16'h8001));
      check("rep_unf1", 32'(unf1), 32'd1);
      frame_chk("rep_f3", fexp(1'b1, 16'h1234, 16'h8001));
      check("rep_unf_hold", 32'(unf1), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
